range_comparator: RTL and testbench

Registered 3-bit magnitude comparator. Three single-bit inputs x (MSB), y, z form an unsigned value 0..7. The block flags values above a threshold, default 5, so 6 and 7 give answer=1. It also supports GE/LT/EQ modes, a runtime-loadable threshold and a saturating hit counter. It sits as a small classifier stage after a 3-bit source, with a one-cycle registered result.

---
 rtl/range_comparator_pkg.sv | 9 +
 rtl/range_comparator_cmp_core.sv | 15 +
 rtl/range_comparator.sv | 41 ++++
 tb/tb_range_comparator.sv | 120 ++++++++++++
 4 files changed

// File: rtl/range_comparator_pkg.sv
// range_comparator_pkg: shared constants for the range comparator
package range_comparator_pkg;
  localparam int VAL_W = 3;
  localparam int CNT_W_DEF = 8;
  localparam logic [1:0] MODE_GT = 2'b00;
  localparam logic [1:0] MODE_GE = 2'b01;
  localparam logic [1:0] MODE_LT = 2'b10;
  localparam logic [1:0] MODE_EQ = 2'b11;
endpackage

// File: rtl/range_comparator_cmp_core.sv
// cmp_core: unsigned 3-bit compare of value against thr selected by mode
module cmp_core
  import range_comparator_pkg::*;
(
  input  logic [VAL_W-1:0] value,
  input  logic [VAL_W-1:0] thr,
  input  logic [1:0]       mode,
  output logic             result
);
  always_comb
    result = mode == MODE_GT ? value >  thr :
             mode == MODE_GE ? value >= thr :
             mode == MODE_LT ? value <  thr :
                               value == thr;
endmodule

// File: rtl/range_comparator.sv
// range_comparator: registered 3-bit magnitude classifier with loadable threshold and hit counter
module range_comparator
  import range_comparator_pkg::*;
#(
  parameter logic [VAL_W-1:0] THRESHOLD = 3'd5,
  parameter int               CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  input  logic [1:0]       mode,
  input  logic             thr_load,
  input  logic [VAL_W-1:0] thr_in,
  output logic             answer,
  output logic             out_valid,
  output logic [CNT_W-1:0] hit_count,
  output logic [VAL_W-1:0] thr
);
  logic result;
  cmp_core u_cmp (
    .value  ({x, y, z}),
    .thr    (thr),
    .mode   (mode),
    .result (result)
  );
  always_ff @(posedge clk)
    if (rst) begin
      answer    <= 1'b0;
      out_valid <= 1'b0;
      hit_count <= '0;
      thr       <= THRESHOLD;
    end else begin
      out_valid <= in_valid;
      if (in_valid) answer <= result;
      if (in_valid && result && !(&hit_count)) hit_count <= hit_count + CNT_W'(1);
      if (thr_load) thr <= thr_in;
    end
endmodule

// File: tb/tb_range_comparator.sv
// tb_range_comparator: directed stimulus with a scoreboard queue of expected outputs
module tb_range_comparator;
  typedef struct packed {
    logic       answer;
    logic       out_valid;
    logic [7:0] hit_count;
    logic [2:0] thr;
  } exp_t;
  logic       clk = 0;
  logic       rst = 0;
  logic       in_valid = 0;
  logic       x = 0, y = 0, z = 0;
  logic [1:0] mode = 0;
  logic       thr_load = 0;
  logic [2:0] thr_in = 0;
  logic       answer, out_valid;
  logic [7:0] hit_count;
  logic [2:0] thr;
  exp_t       sb[$];
  int         tests = 0, fails = 0;
  logic       m_ans = 0, m_ov = 0;
  int         m_cnt = 0, m_thr = 5;
  range_comparator #(.THRESHOLD(3'd5), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y), .z(z),
    .mode(mode), .thr_load(thr_load), .thr_in(thr_in),
    .answer(answer), .out_valid(out_valid), .hit_count(hit_count), .thr(thr)
  );
  always #5 clk = ~clk;
  function automatic logic ref_res(int v, int t, int m);
    if (m == 0) return v > t;
    if (m == 1) return v >= t;
    if (m == 2) return v < t;
    return v == t;
  endfunction
  task automatic chk(string tag, int obs, int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(string tag, int v, logic iv, int md, logic tl, int ti, logic r);
    exp_t e;
    rst = r; in_valid = iv; {x, y, z} = 3'(v); mode = 2'(md); thr_load = tl; thr_in = 3'(ti);
    if (r) begin
      m_ans = 0; m_ov = 0; m_cnt = 0; m_thr = 5;
    end else begin
      if (iv) begin
        m_ans = ref_res(v, m_thr, md);
        if (m_ans && m_cnt < 255) m_cnt++;
      end
      m_ov = iv;
      if (tl) m_thr = ti;
    end
    e = '{answer: m_ans, out_valid: m_ov, hit_count: 8'(m_cnt), thr: 3'(m_thr)};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".answer"}, int'(answer), int'(e.answer));
    chk({tag, ".out_valid"}, int'(out_valid), int'(e.out_valid));
    chk({tag, ".hit_count"}, int'(hit_count), int'(e.hit_count));
    chk({tag, ".thr"}, int'(thr), int'(e.thr));
  endtask
  initial begin
    step("reset", 0, 0, 0, 0, 0, 1);
    chk("reset_ans_const", int'(answer), 0);
    chk("reset_thr_const", int'(thr), 5);
    for (int v = 0; v < 8; v++) begin
      step("sweep", v, 1, 0, 0, 0, 0);
      chk("sweep_ans_const", int'(answer), v >= 6 ? 1 : 0);
    end
    chk("sweep_cnt_const", int'(hit_count), 2);
    for (int i = 0; i < 3; i++) begin
      in_valid = 0;
      step("idle", 0, 0, 0, 0, 0, 0);
      chk("idle_hold_const", int'(answer), 1);
    end
    chk("idle_cnt_const", int'(hit_count), 2);
    step("load_same", 3, 1, 0, 1, 2, 0);
    chk("load_old_thr_const", int'(answer), 0);
    step("load_next", 3, 1, 0, 0, 0, 0);
    chk("load_new_thr_const", int'(answer), 1);
    chk("load_thr_const", int'(thr), 2);
    step("reload5", 0, 0, 0, 1, 5, 0);
    step("gt5", 5, 1, 0, 0, 0, 0);
    chk("gt5_const", int'(answer), 0);
    step("ge5", 5, 1, 1, 0, 0, 0);
    chk("ge5_const", int'(answer), 1);
    step("lt5", 5, 1, 2, 0, 0, 0);
    chk("lt5_const", int'(answer), 0);
    step("eq5", 5, 1, 3, 0, 0, 0);
    chk("eq5_const", int'(answer), 1);
    step("lt4", 4, 1, 2, 0, 0, 0);
    chk("lt4_const", int'(answer), 1);
    step("eq0_thr7", 0, 0, 0, 1, 7, 0);
    step("eq7", 7, 1, 3, 0, 0, 0);
    step("ge0_thr0", 0, 1, 1, 1, 0, 0);
    step("ge0", 0, 1, 1, 0, 0, 0);
    step("lt0", 0, 1, 2, 0, 0, 0);
    step("reload5b", 0, 0, 0, 1, 5, 0);
    for (int i = 0; i < 300; i++) step("sat", 7, 1, 0, 0, 0, 0);
    chk("sat_const", int'(hit_count), 255);
    step("sat_hold", 7, 1, 0, 0, 0, 0);
    chk("sat_hold_const", int'(hit_count), 255);
    step("idle_x", 0, 0, 0, 0, 0, 0);
    step("rs_load2", 3, 1, 0, 1, 2, 0);
    step("rs_mid", 4, 1, 0, 0, 0, 0);
    step("rs_reset", 7, 1, 0, 1, 1, 1);
    chk("rs_thr_const", int'(thr), 5);
    chk("rs_cnt_const", int'(hit_count), 0);
    step("rs_v6", 6, 1, 0, 0, 0, 0);
    chk("rs_v6_const", int'(answer), 1);
    step("rs_v5", 5, 1, 0, 0, 0, 0);
    chk("rs_v5_const", int'(answer), 0);
    chk("rs_cnt2_const", int'(hit_count), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
